// File: rtl/snake_step_scheduler.sv
// =====================================================================
// Module : snake_step_scheduler
// Desc   : Snake game-step controller. It generates the move tick and owns the head position.
//          It also checks wall and food hits, keeps the BCD score and runs the food req/ack handshake.
//          Optional macro SNAKE_SPEEDUP_EN shortens the step period as score2 grows.
// Rev    : 1.0
// =====================================================================
`default_nettype none

module snake_step_scheduler #(
  parameter int TICK_DIV = 1_562_500,
  parameter int STEP     = 10,
  parameter int X_MAX    = 630,
  parameter int Y_MAX    = 470,
  parameter int HEAD_X0  = 320,
  parameter int HEAD_Y0  = 240
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [1:0] move_state,
  input  logic       is_paused,
  input  logic [9:0] food_x,
  input  logic [9:0] food_y,
  input  logic       food_ack,
  output logic       food_req,
  output logic [9:0] head_x,
  output logic [9:0] head_y,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [3:0] score3,
  output logic [3:0] score4,
  output logic       step_pulse,
  output logic       game_over
);

  localparam int CW = $clog2(TICK_DIV + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RUN  = 3'd1;
  localparam logic [2:0] S_EAT  = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_OVER = 3'd4;

  localparam logic [1:0] c_dir_up    = 2'b00;
  localparam logic [1:0] c_dir_down  = 2'b01;
  localparam logic [1:0] c_dir_left  = 2'b10;
  localparam logic [1:0] c_dir_right = 2'b11;

  localparam logic [CW-1:0] c_tick_last = CW'(TICK_DIV - 1);
  localparam logic [9:0]    c_step      = 10'(STEP);
  localparam logic [9:0]    c_x_lim     = 10'(X_MAX - STEP);
  localparam logic [9:0]    c_y_lim     = 10'(Y_MAX - STEP);
  localparam logic [9:0]    c_head_x0   = 10'(HEAD_X0);
  localparam logic [9:0]    c_head_y0   = 10'(HEAD_Y0);

  logic [2:0]    r_state;
  logic [1:0]    r_dir;
  logic [CW-1:0] r_tick_cnt;
  logic [CW-1:0] w_period_last;
  logic [1:0]    w_dir_new;
  logic          w_tick;
  logic          w_off;
  logic          w_hit;
  logic [9:0]    w_next_x;
  logic [9:0]    w_next_y;
  logic          w_carry2;
  logic          w_carry3;
  logic          w_carry4;

`ifdef SNAKE_SPEEDUP_EN
  localparam logic [CW-1:0] c_slice = CW'(TICK_DIV / 16);
  logic [3:0] w_speed_lvl;
  // Clamp at level 9 so the period never drops below TICK_DIV*7/16.
  assign w_speed_lvl   = (score2 > 4'd9) ? 4'd9 : score2;
  assign w_period_last = c_tick_last - (CW'(w_speed_lvl) * c_slice);
`else
  assign w_period_last = c_tick_last;
`endif

  function automatic logic [3:0] bcd_digit(input logic [3:0] digit, input logic carry_in);
    logic [3:0] res;
    res = digit;
    if (carry_in) begin
      res = (digit >= 4'd9) ? 4'd0 : digit + 4'd1;
    end
    return res;
  endfunction

  // A direct reversal would run the head into its own neck, so it keeps the old direction.
  assign w_dir_new = ((move_state[1] == r_dir[1]) && (move_state[0] != r_dir[0])) ? r_dir : move_state;
  assign w_tick    = (r_state == S_RUN) && !is_paused && (r_tick_cnt >= w_period_last);
  assign w_hit     = (w_next_x == food_x) && (w_next_y == food_y);
  assign w_carry2  = (score1 == 4'd9);
  assign w_carry3  = w_carry2 && (score2 == 4'd9);
  assign w_carry4  = w_carry3 && (score3 == 4'd9);
  assign game_over = (r_state == S_OVER);

  // Bounds are compared before any add/subtract so the 10-bit head never wraps.
  always_comb begin
    w_off    = 1'b0;
    w_next_x = head_x;
    w_next_y = head_y;
    case (w_dir_new)
      c_dir_up:    if (head_y < c_step)  w_off = 1'b1; else w_next_y = head_y - c_step;
      c_dir_down:  if (head_y > c_y_lim) w_off = 1'b1; else w_next_y = head_y + c_step;
      c_dir_left:  if (head_x < c_step)  w_off = 1'b1; else w_next_x = head_x - c_step;
      c_dir_right: if (head_x > c_x_lim) w_off = 1'b1; else w_next_x = head_x + c_step;
      default:     w_off = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_dir      <= c_dir_right;
      r_tick_cnt <= '0;
      head_x     <= c_head_x0;
      head_y     <= c_head_y0;
      score1     <= 4'd0;
      score2     <= 4'd0;
      score3     <= 4'd0;
      score4     <= 4'd0;
      food_req   <= 1'b0;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_RUN;
            r_tick_cnt <= '0;
          end
        end
        S_RUN: begin
          if (w_tick) begin
            r_tick_cnt <= '0;
            r_dir      <= w_dir_new;
            if (w_off) begin
              r_state <= S_OVER;
            end else begin
              head_x     <= w_next_x;
              head_y     <= w_next_y;
              step_pulse <= 1'b1;
              if (w_hit) r_state <= S_EAT;
            end
          end else if (!is_paused) begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
          end
        end
        S_EAT: begin
          score1   <= bcd_digit(score1, 1'b1);
          score2   <= bcd_digit(score2, w_carry2);
          score3   <= bcd_digit(score3, w_carry3);
          score4   <= bcd_digit(score4, w_carry4);
          food_req <= 1'b1;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          r_tick_cnt <= '0;
          if (food_ack) begin
            food_req <= 1'b0;
            r_state  <= S_RUN;
          end
        end
        S_OVER: begin
          if (start) begin
            r_state    <= S_RUN;
            r_dir      <= c_dir_right;
            r_tick_cnt <= '0;
            head_x     <= c_head_x0;
            head_y     <= c_head_y0;
            score1     <= 4'd0;
            score2     <= 4'd0;
            score3     <= 4'd0;
            score4     <= 4'd0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_snake_step_scheduler.sv
// =====================================================================
// Module : tb_snake_step_scheduler
// Desc   : Self-checking bench for snake_step_scheduler (TICK_DIV=4): directed table,
//          score-wrap run, async reset mid-handshake and a random phase against a reference model.
// Rev    : 1.0
// =====================================================================
`default_nettype none

module tb_snake_step_scheduler;

  localparam int TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [1:0] move_state;
  logic       is_paused;
  logic [9:0] food_x;
  logic [9:0] food_y;
  logic       food_ack;
  logic       food_req;
  logic [9:0] head_x;
  logic [9:0] head_y;
  logic [3:0] score1, score2, score3, score4;
  logic       step_pulse;
  logic       game_over;

  snake_step_scheduler #(.TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .move_state(move_state),
    .is_paused(is_paused), .food_x(food_x), .food_y(food_y), .food_ack(food_ack),
    .food_req(food_req), .head_x(head_x), .head_y(head_y),
    .score1(score1), .score2(score2), .score3(score3), .score4(score4),
    .step_pulse(step_pulse), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  wire [15:0] score_bcd = {score4, score3, score2, score1};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  typedef struct {
    bit       st;
    bit [1:0] mv;
    bit       pause;
    int       fx;
    int       fy;
    bit       ack;
    int       ncyc;
    int       hx;
    int       hy;
    int       score;
    bit       freq;
    bit       over;
    int       steps;
  } vec_t;

  vec_t vecs [19];

  // Reference model: integer score, signed coordinates, direction as a delta table.
  int m_mode;  // 0 idle, 1 run, 2 eat, 3 wait, 4 over
  int m_hx, m_hy, m_dir, m_score, m_cnt;
  bit m_freq, m_step;
  int dxs [4] = '{0, 0, -10, 10};
  int dys [4] = '{-10, 10, 0, 0};
  int opp [4] = '{1, 0, 3, 2};

  task automatic model_reset();
    m_mode = 0; m_hx = 320; m_hy = 240; m_dir = 3; m_score = 0; m_cnt = 0;
    m_freq = 0; m_step = 0;
  endtask

  task automatic model_step();
    int mv, nx, ny;
    m_step = 0;
    mv = int'(move_state);
    case (m_mode)
      0: if (start) begin m_mode = 1; m_cnt = 0; end
      1: if (!is_paused) begin
           if (m_cnt == TICK_DIV - 1) begin
             m_cnt = 0;
             if (mv != opp[m_dir]) m_dir = mv;
             nx = m_hx + dxs[m_dir];
             ny = m_hy + dys[m_dir];
             if (nx < 0 || nx > 630 || ny < 0 || ny > 470) m_mode = 4;
             else begin
               m_hx = nx; m_hy = ny; m_step = 1;
               if (nx == int'(food_x) && ny == int'(food_y)) m_mode = 2;
             end
           end else m_cnt++;
         end
      2: begin m_score = (m_score + 1) % 10000; m_freq = 1; m_mode = 3; end
      3: begin m_cnt = 0; if (food_ack) begin m_freq = 0; m_mode = 1; end end
      default: if (start) begin
           m_mode = 1; m_cnt = 0; m_hx = 320; m_hy = 240; m_dir = 3; m_score = 0;
         end
    endcase
  endtask

  initial begin
    int nsteps;
    int hx, hy, nx, ny, k, bias, fx, fy, mv;
    bit ok;
    bit [1:0] pat_mv [4] = '{2'b11, 2'b01, 2'b10, 2'b00};
    int pat_dx [4] = '{10, 0, -10, 0};
    int pat_dy [4] = '{0, 10, 0, -10};

    //        st mv     p  fx    fy    ack n   hx   hy   score  fr ov steps
    vecs[0]  = '{1, 2'b11, 0, 1023, 1023, 0, 1,  320, 240, 16'h0, 0, 0, 0};
    vecs[1]  = '{0, 2'b11, 0, 1023, 1023, 0, 4,  330, 240, 16'h0, 0, 0, 1};
    vecs[2]  = '{0, 2'b11, 0, 1023, 1023, 0, 8,  350, 240, 16'h0, 0, 0, 2};
    vecs[3]  = '{0, 2'b11, 0, 360,  240,  0, 4,  360, 240, 16'h0, 0, 0, 1};
    vecs[4]  = '{0, 2'b11, 0, 360,  240,  0, 1,  360, 240, 16'h1, 1, 0, 0};
    vecs[5]  = '{0, 2'b11, 0, 360,  240,  0, 5,  360, 240, 16'h1, 1, 0, 0};
    vecs[6]  = '{0, 2'b11, 0, 1023, 1023, 1, 1,  360, 240, 16'h1, 0, 0, 0};
    vecs[7]  = '{0, 2'b11, 0, 1023, 1023, 0, 4,  370, 240, 16'h1, 0, 0, 1};
    vecs[8]  = '{0, 2'b10, 0, 1023, 1023, 0, 4,  380, 240, 16'h1, 0, 0, 1};
    vecs[9]  = '{0, 2'b11, 0, 1023, 1023, 0, 2,  380, 240, 16'h1, 0, 0, 0};
    vecs[10] = '{0, 2'b11, 1, 1023, 1023, 0, 20, 380, 240, 16'h1, 0, 0, 0};
    vecs[11] = '{0, 2'b11, 0, 1023, 1023, 0, 1,  380, 240, 16'h1, 0, 0, 0};
    vecs[12] = '{0, 2'b11, 0, 1023, 1023, 0, 1,  390, 240, 16'h1, 0, 0, 1};
    vecs[13] = '{0, 2'b00, 0, 1023, 1023, 0, 4,  390, 230, 16'h1, 0, 0, 1};
    vecs[14] = '{0, 2'b11, 0, 1023, 1023, 0, 96, 630, 230, 16'h1, 0, 0, 24};
    vecs[15] = '{0, 2'b11, 0, 1023, 1023, 0, 4,  630, 230, 16'h1, 0, 1, 0};
    vecs[16] = '{0, 2'b11, 0, 1023, 1023, 0, 10, 630, 230, 16'h1, 0, 1, 0};
    vecs[17] = '{1, 2'b11, 0, 1023, 1023, 0, 1,  320, 240, 16'h0, 0, 0, 0};
    vecs[18] = '{0, 2'b11, 0, 1023, 1023, 0, 4,  330, 240, 16'h0, 0, 0, 1};

    reset_n = 1'b0; start = 1'b0; move_state = 2'b11; is_paused = 1'b0;
    food_x = 10'd1023; food_y = 10'd1023; food_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_head", {head_x, head_y}, {10'd320, 10'd240});
    check("reset_flags", {food_req, step_pulse, game_over, score_bcd}, 19'd0);

    reset_n = 1'b1;
    nsteps = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (step_pulse) nsteps++;
    end
    check("idle_steps", nsteps, 0);
    check("idle_head", {head_x, head_y}, {10'd320, 10'd240});
    check("idle_score", score_bcd, 16'h0);

    for (int i = 0; i < 19; i++) begin
      start = vecs[i].st; move_state = vecs[i].mv; is_paused = vecs[i].pause;
      food_x = 10'(vecs[i].fx); food_y = 10'(vecs[i].fy); food_ack = vecs[i].ack;
      nsteps = 0;
      for (int c = 0; c < vecs[i].ncyc; c++) begin
        @(negedge clk);
        start = 1'b0;
        if (step_pulse) nsteps++;
      end
      check($sformatf("vec%0d_head", i), {head_x, head_y}, {10'(vecs[i].hx), 10'(vecs[i].hy)});
      check($sformatf("vec%0d_score", i), score_bcd, 16'(vecs[i].score));
      check($sformatf("vec%0d_flags", i), {food_req, game_over}, {vecs[i].freq, vecs[i].over});
      check($sformatf("vec%0d_steps", i), nsteps, vecs[i].steps);
    end

    // Eat on every step around a 10x10 square until the score wraps past 9999.
    hx = 330; hy = 240; food_ack = 1'b1;
    for (int n = 1; n <= 10000; n++) begin
      k = (n - 1) % 4;
      move_state = pat_mv[k];
      nx = hx + pat_dx[k]; ny = hy + pat_dy[k];
      food_x = 10'(nx); food_y = 10'(ny);
      ok = 0;
      for (int c = 0; c < 20 && !ok; c++) begin
        @(negedge clk);
        if (step_pulse) ok = 1;
      end
      if (!ok) begin
        check("eat_step_timeout", 0, 1);
        break;
      end
      @(negedge clk);
      hx = nx; hy = ny;
      if (n == 1000 || n == 10000 || n == 9999) begin
        check($sformatf("eat_score_%0d", n), score_bcd, to_bcd(n % 10000));
      end else if (score_bcd !== to_bcd(n % 10000)) begin
        check($sformatf("eat_score_%0d", n), score_bcd, to_bcd(n % 10000));
        break;
      end
    end
    check("wrap_digits", {score4, score3, score2, score1}, 16'h0000);

    // Mid-handshake: ack withheld, then reset drops food_req without a clock edge.
    food_ack = 1'b0;
    @(negedge clk);
    check("handshake_hold", food_req, 1'b1);
    #2 reset_n = 1'b0;
    #1 check("async_drop", {food_req, head_x, head_y}, {1'b0, 10'd320, 10'd240});
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();

    bias = 3;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      check("rand_cycle", {head_x, head_y, score_bcd, step_pulse, food_req, game_over},
            {10'(m_hx), 10'(m_hy), to_bcd(m_score), m_step, m_freq, (m_mode == 4)});
      if (errors > 10) break;
      if (cyc % 150 == 0) bias = int'($urandom_range(0, 3));
      mv = ($urandom_range(0, 9) < 7) ? bias : int'($urandom_range(0, 3));
      move_state = 2'(mv);
      start = ($urandom_range(0, 99) < 3);
      is_paused = ($urandom_range(0, 99) < 15);
      food_ack = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 9) < 4) begin
        fx = m_hx + dxs[mv]; fy = m_hy + dys[mv];
        if (fx < 0 || fy < 0) begin fx = 1023; fy = 1023; end
      end else begin
        fx = int'($urandom_range(0, 63)) * 10; fy = int'($urandom_range(0, 47)) * 10;
      end
      food_x = 10'(fx); food_y = 10'(fy);
      @(posedge clk);
      model_step();
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
